mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
//  Parametrised MEM stage with a registered MEM/WB boundary.
//  - Loads/stores byte, half or word data, with sign or zero extension on loads.
//  - Detects misaligned accesses.
//  - Optional memory wait states, with a valid/ready handshake to EX/MEM.
//  - Sits between EX/MEM and the WB stage.
// PARAMETERS
//  XLEN      32  datapath width (bits)
//  ADDR_BITS 12  byte-address bits decoded; upper MemAddr bits ignored, so accesses wrap modulo 2^ADDR_BITS
//  MEM_WAIT  0   extra wait cycles per aligned memory access (0..7)
// PORTS
//  clk               in   1     clock, rising edge
//  reset_n           in   1     reset; asynchronous, active-high (despite the name)
//  in_valid          in   1     EX/MEM holds a valid op
//  in_ready          out  1     stage accepts op this cycle
//  RegWrite          in   1     WB write enable
//  MemtoReg          in   2     WB mux select, passed through
//  RegDestination    in   5     rd, passed through
//  MemRead           in   1     load
//  MemWrite          in   1     store
//  MemSize           in   2     00 byte, 01 half, 10 word; 11 treated as word
//  MemUnsigned       in   1     1 = zero-extend load
//  MemAddr           in   XLEN  ALU result / byte address
//  WriteData         in   XLEN  store data (low bits used for byte/half)
//  pc                in   XLEN  instruction pc
//  out_valid         out  1     MEM/WB register holds a completed op
//  ReadData_WB       out  XLEN  extended load data
//  ALUresult_WB      out  XLEN  MemAddr of completed op
//  pc_WB             out  XLEN  pc+4 of completed op
//  RegWrite_WB       out  1     gated write enable
//  MemtoReg_WB       out  2
//  RegDestination_WB out  5
//  misaligned_WB     out  1     completed op was misaligned
// BEHAVIOUR
//  - Reset: every output register 0; out_valid=0; FSM IDLE; wait counter 0. Memory array is NOT cleared.
//  - FSM IDLE/WAIT. in_ready = (state==IDLE). Accept = in_valid & in_ready; accepted fields latch into a request register.
//  - Mem op = MemRead|MemWrite. MEM_WAIT=0, non-mem op, or misaligned op: completes on the accept edge (1-cycle latency, 1 op/cycle).
//  - Otherwise: IDLE->WAIT on accept with cnt=MEM_WAIT. Decrement each cycle; at cnt==1 the next edge completes the op -> IDLE.
//  - Latency is MEM_WAIT+1 cycles.
//  - Completion edge, all in one edge:
//    - store commits to memory;
//    - MEM/WB regs load;
//    - out_valid=1 for exactly one cycle;
//    - pc_WB = pc+4, truncated to XLEN.
//  - No completion that cycle: out_valid=0, RegWrite_WB=0, other WB regs hold.
//  - Index = addr[ADDR_BITS-1:2]; lane = addr[1:0].
//    - Byte store writes WriteData[7:0] to the lane.
//    - Half store writes [15:0] to lanes {addr[1],0} and {addr[1],1}.
//    - Word store writes all lanes.
//  - Load: read is combinational from the sub-module. Select byte/half at the lane, then sign-extend (MemUnsigned=0) or zero-extend.
//  - Non-load ops: ReadData_WB=0.
//  - Misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
//    - No memory write; ReadData_WB=0; RegWrite_WB=0; misaligned_WB=1.
//  - MemRead & MemWrite both set: treated as a store; ReadData_WB=0.
//  - Reset during WAIT: op aborted, store not committed, out_valid=0.
//  - Addresses >= 2^ADDR_BITS alias; no error is flagged.
// STRUCTURE
//  - Shared package: MemSize encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encoding, XLEN default.
//  - Sub-module dmem_bank: 2^(ADDR_BITS-2) x XLEN array, per-byte write enables, async read, sync write, no reset.
//  - Extension, alignment logic, FSM and MEM/WB register live in mem_stage_pipe.
// TESTING
//  1. MEM_WAIT=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> out_valid each cycle, ReadData_WB=0xDEADBEEF, pc_WB=pc+4.
//  2. SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
//  3. LH @0x11 -> misaligned_WB=1, RegWrite_WB=0, ReadData_WB=0, memory unchanged. SW @0x12 -> not committed.
//  4. MEM_WAIT=3: LW accepted -> in_ready=0 for 3 cycles; out_valid 4 cycles after accept. Non-mem op completes in 1 cycle.
//  5. MEM_WAIT=3: assert reset_n mid-WAIT of SW 0x1234 @0x20 -> all outputs 0 immediately; later LW @0x20 returns the old value.
//  6. ADDR_BITS=12: SW @0x1004, LW @0x004 -> same data (alias). in_valid=0 bubble -> out_valid=0, RegWrite_WB=0.

Source files
------------

// File: rtl/mem_stage_pipe_pkg.sv
// Shared definitions for the MEM stage: default datapath width, MemSize
// encodings, FSM state encoding and the alignment check helper.
package mem_stage_pipe_pkg;

  localparam int XLEN_DEF = 32;

  // MemSize encodings; 2'b11 is not listed and is handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // A half must sit on an even byte, a word (or the 2'b11 alias) on a
  // multiple of four; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_pipe_dmem_bank.sv
// Data memory bank for the MEM stage.
// 2^DEPTH_BITS words of XLEN bits, asynchronous read, synchronous write with
// one write enable per byte lane. The array has no reset; contents survive
// a stage reset.
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   per-byte write enables (bit b writes byte lane b)
//   i_idx    in   word index shared by read and write
//   i_wdata  in   write data, already placed in its byte lanes
//   o_rdata  out  word at i_idx, combinational
module dmem_bank
  import mem_stage_pipe_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clk,
  input  logic [XLEN/8-1:0]     i_we,
  input  logic [DEPTH_BITS-1:0] i_idx,
  input  logic [XLEN-1:0]       i_wdata,
  output logic [XLEN-1:0]       o_rdata
);

  logic [XLEN-1:0] r_mem [2**DEPTH_BITS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < XLEN / 8; b++) begin
      if (i_we[b]) r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage with a registered MEM/WB boundary.
// Performs byte/half/word loads (sign or zero extended) and stores, flags
// misaligned accesses (which then neither write memory nor write back), and
// optionally stretches each aligned memory access by MEM_WAIT wait cycles.
// Ports:
//   clk, reset_n          clock; reset is asynchronous and active-high
//   in_valid / in_ready   handshake with EX/MEM
//   RegWrite..pc          EX/MEM control, address and data fields
//   out_valid             MEM/WB holds an op completed on the last edge
//   *_WB                  MEM/WB register outputs
//   o_dbg_state           current FSM state, for observation only
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready.
// in_ready is high exactly while the FSM is IDLE and does not depend on
// in_valid. out_valid is a one-cycle pulse per completed op; WB has no
// back-pressure.
module mem_stage_pipe
  import mem_stage_pipe_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int ADDR_BITS = 12,
  parameter int MEM_WAIT  = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            RegWrite,
  input  logic [1:0]      MemtoReg,
  input  logic [4:0]      RegDestination,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic [1:0]      MemSize,
  input  logic            MemUnsigned,
  input  logic [XLEN-1:0] MemAddr,
  input  logic [XLEN-1:0] WriteData,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  output logic [XLEN-1:0] ReadData_WB,
  output logic [XLEN-1:0] ALUresult_WB,
  output logic [XLEN-1:0] pc_WB,
  output logic            RegWrite_WB,
  output logic [1:0]      MemtoReg_WB,
  output logic [4:0]      RegDestination_WB,
  output logic            misaligned_WB,
  output state_e          o_dbg_state
);

  localparam int NB = XLEN / 8;

  state_e          r_state, w_state_nxt;
  logic [2:0]      r_cnt, w_cnt_nxt;

  // Request register: holds the accepted op while the FSM waits.
  logic            r_req_regwrite, r_req_read, r_req_write, r_req_unsigned;
  logic [1:0]      r_req_memtoreg, r_req_size;
  logic [4:0]      r_req_rd;
  logic [XLEN-1:0] r_req_addr, r_req_wdata, r_req_pc;

  // MEM/WB register
  logic            r_out_valid, r_regwrite_wb, r_mis_wb;
  logic [1:0]      r_memtoreg_wb;
  logic [4:0]      r_rd_wb;
  logic [XLEN-1:0] r_rdata_wb, r_alu_wb, r_pc_wb;

  logic            w_accept, w_in_wait, w_memop, w_mis, w_fast, w_done, w_is_load;
  logic            w_sel_regwrite, w_sel_read, w_sel_write, w_sel_unsigned;
  logic [1:0]      w_sel_memtoreg, w_sel_size, w_lane;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_addr, w_sel_wdata, w_sel_pc;
  logic [XLEN-1:0] w_rdata, w_load_ext, w_wdata_lanes;
  logic [NB-1:0]   w_be, w_we;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign in_ready  = (r_state == ST_IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_in_wait = (r_state == ST_WAIT);

  // The op being worked on: straight from EX/MEM while IDLE (it can only
  // complete on its accept edge there), from the request register in WAIT.
  assign w_sel_regwrite = w_in_wait ? r_req_regwrite : RegWrite;
  assign w_sel_memtoreg = w_in_wait ? r_req_memtoreg : MemtoReg;
  assign w_sel_rd       = w_in_wait ? r_req_rd       : RegDestination;
  assign w_sel_read     = w_in_wait ? r_req_read     : MemRead;
  assign w_sel_write    = w_in_wait ? r_req_write    : MemWrite;
  assign w_sel_size     = w_in_wait ? r_req_size     : MemSize;
  assign w_sel_unsigned = w_in_wait ? r_req_unsigned : MemUnsigned;
  assign w_sel_addr     = w_in_wait ? r_req_addr     : MemAddr;
  assign w_sel_wdata    = w_in_wait ? r_req_wdata    : WriteData;
  assign w_sel_pc       = w_in_wait ? r_req_pc       : pc;

  assign w_lane    = w_sel_addr[1:0];
  assign w_memop   = w_sel_read | w_sel_write;
  // Alignment only matters for ops that touch memory; an ALU result is free
  // to be any value.
  assign w_mis     = w_memop & is_misaligned(w_sel_size, w_lane);
  // A store wins when both MemRead and MemWrite are set.
  assign w_is_load = w_sel_read & ~w_sel_write & ~w_mis;

  // Ops that never enter WAIT finish on their accept edge.
  assign w_fast = w_accept & ((MEM_WAIT == 0) | ~w_memop | w_mis);
  assign w_done = w_fast | (w_in_wait & (r_cnt == 3'd1));

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_fast) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 3'(MEM_WAIT);
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_req_regwrite <= 1'b0;
      r_req_read     <= 1'b0;
      r_req_write    <= 1'b0;
      r_req_unsigned <= 1'b0;
      r_req_memtoreg <= '0;
      r_req_size     <= '0;
      r_req_rd       <= '0;
      r_req_addr     <= '0;
      r_req_wdata    <= '0;
      r_req_pc       <= '0;
    end else if (w_accept) begin
      r_req_regwrite <= RegWrite;
      r_req_read     <= MemRead;
      r_req_write    <= MemWrite;
      r_req_unsigned <= MemUnsigned;
      r_req_memtoreg <= MemtoReg;
      r_req_size     <= MemSize;
      r_req_rd       <= RegDestination;
      r_req_addr     <= MemAddr;
      r_req_wdata    <= WriteData;
      r_req_pc       <= pc;
    end
  end

  // Store lane placement: the data is replicated across lanes and the byte
  // enables pick which copy lands.
  always_comb begin
    w_be          = '1;
    w_wdata_lanes = w_sel_wdata;
    case (w_sel_size)
      SZ_BYTE: begin
        w_be          = NB'(1) << w_lane;
        w_wdata_lanes = {NB{w_sel_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be          = NB'(3) << {w_lane[1], 1'b0};
        w_wdata_lanes = {(NB/2){w_sel_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_we = (w_done & w_sel_write & ~w_mis) ? w_be : '0;

  dmem_bank #(
    .XLEN       (XLEN),
    .DEPTH_BITS (ADDR_BITS - 2)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_idx   (w_sel_addr[ADDR_BITS-1:2]),
    .i_wdata (w_wdata_lanes),
    .o_rdata (w_rdata)
  );

  assign w_byte = w_rdata[{w_lane, 3'b000} +: 8];
  assign w_half = w_rdata[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_ext = w_rdata;
    case (w_sel_size)
      SZ_BYTE: w_load_ext = w_sel_unsigned ? XLEN'(w_byte) : {{(XLEN-8){w_byte[7]}}, w_byte};
      SZ_HALF: w_load_ext = w_sel_unsigned ? XLEN'(w_half) : {{(XLEN-16){w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_out_valid   <= 1'b0;
      r_regwrite_wb <= 1'b0;
      r_mis_wb      <= 1'b0;
      r_memtoreg_wb <= '0;
      r_rd_wb       <= '0;
      r_rdata_wb    <= '0;
      r_alu_wb      <= '0;
      r_pc_wb       <= '0;
    end else begin
      r_out_valid <= w_done;
      if (w_done) begin
        r_regwrite_wb <= w_sel_regwrite & ~w_mis;
        r_mis_wb      <= w_mis;
        r_memtoreg_wb <= w_sel_memtoreg;
        r_rd_wb       <= w_sel_rd;
        r_rdata_wb    <= w_is_load ? w_load_ext : '0;
        r_alu_wb      <= w_sel_addr;
        r_pc_wb       <= w_sel_pc + XLEN'(4);
      end else begin
        // Keep WB from writing a stale rd; the rest simply holds.
        r_regwrite_wb <= 1'b0;
      end
    end
  end

  assign out_valid         = r_out_valid;
  assign ReadData_WB       = r_rdata_wb;
  assign ALUresult_WB      = r_alu_wb;
  assign pc_WB             = r_pc_wb;
  assign RegWrite_WB       = r_regwrite_wb;
  assign MemtoReg_WB       = r_memtoreg_wb;
  assign RegDestination_WB = r_rd_wb;
  assign misaligned_WB     = r_mis_wb;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Testbench for mem_stage_pipe: one instance with no wait states driven from
// a vector table, one with MEM_WAIT=3 driven by hand-written sequences.
module tb_mem_stage_pipe;
  import mem_stage_pipe_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [1:0]  memtoreg;
    logic [4:0]  rd;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } op_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        regwrite;
    logic [1:0]  memtoreg;
    logic [4:0]  rd;
    logic        mis;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t exp;
  } vec_t;

  localparam int NV = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, b_rst;
  op_t  a_op, b_op;

  logic        a_in_ready, a_out_valid, a_rw, a_mis;
  logic [31:0] a_rdata, a_alu, a_pc;
  logic [1:0]  a_mtr;
  logic [4:0]  a_rd;
  state_e      a_dbg;

  logic        b_in_ready, b_out_valid, b_rw, b_mis;
  logic [31:0] b_rdata, b_alu, b_pc;
  logic [1:0]  b_mtr;
  logic [4:0]  b_rd;
  state_e      b_dbg;

  mem_stage_pipe #(.XLEN(32), .ADDR_BITS(12), .MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset_n(a_rst), .in_valid(a_op.valid), .in_ready(a_in_ready),
    .RegWrite(a_op.regwrite), .MemtoReg(a_op.memtoreg), .RegDestination(a_op.rd),
    .MemRead(a_op.rd_en), .MemWrite(a_op.wr_en), .MemSize(a_op.size),
    .MemUnsigned(a_op.uns), .MemAddr(a_op.addr), .WriteData(a_op.wdata), .pc(a_op.pc),
    .out_valid(a_out_valid), .ReadData_WB(a_rdata), .ALUresult_WB(a_alu), .pc_WB(a_pc),
    .RegWrite_WB(a_rw), .MemtoReg_WB(a_mtr), .RegDestination_WB(a_rd),
    .misaligned_WB(a_mis), .o_dbg_state(a_dbg)
  );

  mem_stage_pipe #(.XLEN(32), .ADDR_BITS(12), .MEM_WAIT(3)) u_dut3 (
    .clk(clk), .reset_n(b_rst), .in_valid(b_op.valid), .in_ready(b_in_ready),
    .RegWrite(b_op.regwrite), .MemtoReg(b_op.memtoreg), .RegDestination(b_op.rd),
    .MemRead(b_op.rd_en), .MemWrite(b_op.wr_en), .MemSize(b_op.size),
    .MemUnsigned(b_op.uns), .MemAddr(b_op.addr), .WriteData(b_op.wdata), .pc(b_op.pc),
    .out_valid(b_out_valid), .ReadData_WB(b_rdata), .ALUresult_WB(b_alu), .pc_WB(b_pc),
    .RegWrite_WB(b_rw), .MemtoReg_WB(b_mtr), .RegDestination_WB(b_rd),
    .misaligned_WB(b_mis), .o_dbg_state(b_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cmp_wb(input string tag, input exp_t e, input logic [31:0] rdata,
                        input logic [31:0] alu, input logic [31:0] pc4, input logic rw,
                        input logic [1:0] mtr, input logic [4:0] rd, input logic mis);
    check({tag, " ReadData_WB"}, rdata, e.rdata);
    check({tag, " ALUresult_WB"}, alu, e.alu);
    check({tag, " pc_WB"}, pc4, e.pc4);
    check({tag, " RegWrite_WB"}, 32'(rw), 32'(e.regwrite));
    check({tag, " MemtoReg_WB"}, 32'(mtr), 32'(e.memtoreg));
    check({tag, " RegDestination_WB"}, 32'(rd), 32'(e.rd));
    check({tag, " misaligned_WB"}, 32'(mis), 32'(e.mis));
  endtask

  // ---------------- scoreboards ----------------
  exp_t exp_q0[$];
  exp_t exp_q3[$];

  always @(negedge clk) begin
    if (a_out_valid === 1'b1) begin
      if (exp_q0.size() == 0) check("dut0 unexpected out_valid", 32'(a_out_valid), 32'd0);
      else cmp_wb("dut0", exp_q0.pop_front(), a_rdata, a_alu, a_pc, a_rw, a_mtr, a_rd, a_mis);
    end
  end

  always @(negedge clk) begin
    if (b_out_valid === 1'b1) begin
      if (exp_q3.size() == 0) check("dut3 unexpected out_valid", 32'(b_out_valid), 32'd0);
      else cmp_wb("dut3", exp_q3.pop_front(), b_rdata, b_alu, b_pc, b_rw, b_mtr, b_rd, b_mis);
    end
  end

  // ---------------- driver helpers ----------------
  function automatic op_t mk_op(input logic rw, input logic [1:0] mtr, input logic [4:0] rd,
                                input logic r, input logic w, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] pc);
    op_t o;
    o.valid = 1'b1; o.regwrite = rw; o.memtoreg = mtr; o.rd = rd;
    o.rd_en = r; o.wr_en = w; o.size = sz; o.uns = uns;
    o.addr = addr; o.wdata = wd; o.pc = pc;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] rdata, input logic [31:0] alu,
                                  input logic [31:0] pc4, input logic rw,
                                  input logic [1:0] mtr, input logic [4:0] rd, input logic mis);
    exp_t e;
    e.rdata = rdata; e.alu = alu; e.pc4 = pc4; e.regwrite = rw;
    e.memtoreg = mtr; e.rd = rd; e.mis = mis;
    return e;
  endfunction

  // Issue one op to the MEM_WAIT=3 instance and measure completion latency
  // (cycles from the accept edge) and how many cycles in_ready stayed low.
  task automatic issue3(input string name, input op_t op, input exp_t e,
                        input int exp_lat, input int exp_busy);
    int lat;
    int busy;
    bit done;
    lat = 0; busy = 0; done = 1'b0;
    @(posedge clk); #1;
    check({name, " in_ready before issue"}, 32'(b_in_ready), 32'd1);
    b_op = op;
    exp_q3.push_back(e);
    @(posedge clk); #1;
    b_op = '0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (b_out_valid === 1'b1) begin
        done = 1'b1;
        lat  = n;
      end else if (b_in_ready === 1'b0) begin
        busy++;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " in_ready low cycles"}, 32'(busy), 32'(exp_busy));
  endtask

  vec_t vecs[NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    //             rw  mtr rd  rd  wr  size  uns addr         wdata        pc
    vecs[0]  = '{mk_op(0, 0, 0, 0, 1, SZ_WORD, 0, 32'h10,   32'hDEADBEEF, 32'h100), mk_exp(32'h0,        32'h10,   32'h104, 0, 0, 0,  0)};
    vecs[1]  = '{mk_op(1, 1, 5, 1, 0, SZ_WORD, 0, 32'h10,   32'h0,        32'h104), mk_exp(32'hDEADBEEF, 32'h10,   32'h108, 1, 1, 5,  0)};
    vecs[2]  = '{mk_op(0, 0, 0, 0, 1, SZ_BYTE, 0, 32'h13,   32'h12345680, 32'h108), mk_exp(32'h0,        32'h13,   32'h10C, 0, 0, 0,  0)};
    vecs[3]  = '{mk_op(1, 1, 6, 1, 0, SZ_BYTE, 0, 32'h13,   32'h0,        32'h10C), mk_exp(32'hFFFFFF80, 32'h13,   32'h110, 1, 1, 6,  0)};
    vecs[4]  = '{mk_op(1, 1, 7, 1, 0, SZ_BYTE, 1, 32'h13,   32'h0,        32'h110), mk_exp(32'h00000080, 32'h13,   32'h114, 1, 1, 7,  0)};
    vecs[5]  = '{mk_op(1, 1, 8, 1, 0, SZ_WORD, 0, 32'h10,   32'h0,        32'h114), mk_exp(32'h80ADBEEF, 32'h10,   32'h118, 1, 1, 8,  0)};
    vecs[6]  = '{mk_op(1, 1, 9, 1, 0, SZ_HALF, 0, 32'h11,   32'h0,        32'h118), mk_exp(32'h0,        32'h11,   32'h11C, 0, 1, 9,  1)};
    vecs[7]  = '{mk_op(0, 0, 0, 0, 1, SZ_WORD, 0, 32'h12,   32'hCAFEF00D, 32'h11C), mk_exp(32'h0,        32'h12,   32'h120, 0, 0, 0,  1)};
    vecs[8]  = '{mk_op(1, 1, 10, 1, 0, SZ_WORD, 0, 32'h10,  32'h0,        32'h120), mk_exp(32'h80ADBEEF, 32'h10,   32'h124, 1, 1, 10, 0)};
    vecs[9]  = '{mk_op(1, 1, 11, 1, 0, SZ_HALF, 1, 32'h12,  32'h0,        32'h124), mk_exp(32'h000080AD, 32'h12,   32'h128, 1, 1, 11, 0)};
    vecs[10] = '{mk_op(1, 1, 12, 1, 0, SZ_HALF, 0, 32'h12,  32'h0,        32'h128), mk_exp(32'hFFFF80AD, 32'h12,   32'h12C, 1, 1, 12, 0)};
    vecs[11] = '{mk_op(0, 0, 0, 0, 1, SZ_WORD, 0, 32'h14,   32'h0,        32'h12C), mk_exp(32'h0,        32'h14,   32'h130, 0, 0, 0,  0)};
    vecs[12] = '{mk_op(0, 0, 0, 0, 1, SZ_HALF, 0, 32'h16,   32'hABCD7FFF, 32'h130), mk_exp(32'h0,        32'h16,   32'h134, 0, 0, 0,  0)};
    vecs[13] = '{mk_op(1, 1, 13, 1, 0, SZ_WORD, 0, 32'h14,  32'h0,        32'h134), mk_exp(32'h7FFF0000, 32'h14,   32'h138, 1, 1, 13, 0)};
    vecs[14] = '{mk_op(1, 1, 14, 1, 0, SZ_HALF, 0, 32'h16,  32'h0,        32'h138), mk_exp(32'h00007FFF, 32'h16,   32'h13C, 1, 1, 14, 0)};
    vecs[15] = '{mk_op(0, 0, 0, 0, 1, SZ_WORD, 0, 32'h1004, 32'h11223344, 32'h13C), mk_exp(32'h0,        32'h1004, 32'h140, 0, 0, 0,  0)};
    vecs[16] = '{mk_op(1, 1, 15, 1, 0, SZ_WORD, 0, 32'h004, 32'h0,        32'h140), mk_exp(32'h11223344, 32'h4,    32'h144, 1, 1, 15, 0)};
    vecs[17] = '{mk_op(1, 0, 16, 0, 0, SZ_BYTE, 0, 32'h1235, 32'h0,  32'hFFFFFFFC), mk_exp(32'h0,        32'h1235, 32'h0,   1, 0, 16, 0)};
    vecs[18] = '{mk_op(0, 0, 0, 1, 1, SZ_WORD, 0, 32'h18,   32'hA5A5A5A5, 32'h144), mk_exp(32'h0,        32'h18,   32'h148, 0, 0, 0,  0)};
    vecs[19] = '{mk_op(1, 1, 17, 1, 0, 2'b11,  0, 32'h18,   32'h0,        32'h148), mk_exp(32'hA5A5A5A5, 32'h18,   32'h14C, 1, 1, 17, 0)};

    a_op  = '0;
    b_op  = '0;
    a_rst = 1'b1;
    b_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dut0 out_valid", 32'(a_out_valid), 32'd0);
    check("reset dut0 ReadData_WB", a_rdata, 32'd0);
    check("reset dut0 pc_WB", a_pc, 32'd0);
    check("reset dut0 RegWrite_WB", 32'(a_rw), 32'd0);
    check("reset dut0 in_ready", 32'(a_in_ready), 32'd1);
    check("reset dut0 state", 32'(a_dbg), 32'(ST_IDLE));
    check("reset dut3 out_valid", 32'(b_out_valid), 32'd0);
    check("reset dut3 ALUresult_WB", b_alu, 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Table-driven back-to-back ops on the no-wait instance.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      check("dut0 in_ready streaming", 32'(a_in_ready), 32'd1);
      a_op = vecs[i].op;
      exp_q0.push_back(vecs[i].exp);
    end
    @(posedge clk); #1;
    a_op = '0;
    @(negedge clk);   // last table op reported here by the scoreboard
    @(negedge clk);   // bubble: nothing was offered
    check("bubble out_valid", 32'(a_out_valid), 32'd0);
    check("bubble RegWrite_WB", 32'(a_rw), 32'd0);
    check("bubble ALUresult_WB holds", a_alu, vecs[NV-1].exp.alu);
    check("bubble ReadData_WB holds", a_rdata, vecs[NV-1].exp.rdata);

    // Wait-state instance.
    issue3("w3 SW", mk_op(0, 0, 0, 0, 1, SZ_WORD, 0, 32'h20, 32'hAAAA5555, 32'h200),
           mk_exp(32'h0, 32'h20, 32'h204, 0, 0, 0, 0), 4, 3);
    issue3("w3 LW", mk_op(1, 1, 3, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h204),
           mk_exp(32'hAAAA5555, 32'h20, 32'h208, 1, 1, 3, 0), 4, 3);
    issue3("w3 ALU", mk_op(1, 0, 4, 0, 0, SZ_WORD, 0, 32'h77, 32'h0, 32'h208),
           mk_exp(32'h0, 32'h77, 32'h20C, 1, 0, 4, 0), 1, 0);
    issue3("w3 misaligned LW", mk_op(1, 1, 5, 1, 0, SZ_WORD, 0, 32'h21, 32'h0, 32'h20C),
           mk_exp(32'h0, 32'h21, 32'h210, 0, 1, 5, 1), 1, 0);

    // Reset in the middle of a waiting store: nothing completes or commits.
    @(posedge clk); #1;
    b_op = mk_op(0, 0, 0, 0, 1, SZ_WORD, 0, 32'h20, 32'h00001234, 32'h210);
    @(posedge clk); #1;
    b_op = '0;
    @(negedge clk);
    check("abort state in WAIT", 32'(b_dbg), 32'(ST_WAIT));
    @(negedge clk);
    b_rst = 1'b1;
    #1;
    check("abort out_valid", 32'(b_out_valid), 32'd0);
    check("abort ReadData_WB", b_rdata, 32'd0);
    check("abort ALUresult_WB", b_alu, 32'd0);
    check("abort pc_WB", b_pc, 32'd0);
    check("abort RegWrite_WB", 32'(b_rw), 32'd0);
    check("abort MemtoReg_WB", 32'(b_mtr), 32'd0);
    check("abort RegDestination_WB", 32'(b_rd), 32'd0);
    check("abort misaligned_WB", 32'(b_mis), 32'd0);
    check("abort in_ready", 32'(b_in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_rst = 1'b0;
    issue3("w3 LW after abort", mk_op(1, 1, 6, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h300),
           mk_exp(32'hAAAA5555, 32'h20, 32'h304, 1, 1, 6, 0), 4, 3);

    repeat (2) @(negedge clk);
    check("dut0 scoreboard drained", 32'(exp_q0.size()), 32'd0);
    check("dut3 scoreboard drained", 32'(exp_q3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
